// File: rtl/multi_ball_hit_controller_if.sv
// Bundle between the object drawers / ball physics blocks and the per-frame hit controller.
// The master side drives drawing requests and ball state; the slave side returns resolved results.
interface multi_ball_hit_controller_if #(
    parameter int NUM_BALLS = 2,
    parameter int NUM_HOLES = 6,
    parameter int POS_W     = 11,
    parameter int VEL_W     = 11
);
    logic                         startOfFrame;
    logic [NUM_BALLS-1:0]         ballDR;
    logic                         bordersDR;
    logic [NUM_HOLES-1:0]         holeDR;
    logic [NUM_BALLS*POS_W-1:0]   ballPosX;
    logic [NUM_BALLS*POS_W-1:0]   ballPosY;
    logic [NUM_BALLS*VEL_W-1:0]   ballVelX;
    logic [NUM_BALLS*VEL_W-1:0]   ballVelY;
    logic [NUM_BALLS*VEL_W-1:0]   ballVelXOut;
    logic [NUM_BALLS*VEL_W-1:0]   ballVelYOut;
    logic [NUM_BALLS-1:0]         collisionOccurred;
    logic [NUM_BALLS-1:0]         holeHit;
    logic [NUM_BALLS*3-1:0]       holeNum;
    logic                         resultValid;

    modport master (
        output startOfFrame, ballDR, bordersDR, holeDR,
        output ballPosX, ballPosY, ballVelX, ballVelY,
        input  ballVelXOut, ballVelYOut, collisionOccurred, holeHit, holeNum, resultValid
    );

    modport slave (
        input  startOfFrame, ballDR, bordersDR, holeDR,
        input  ballPosX, ballPosY, ballVelX, ballVelY,
        output ballVelXOut, ballVelYOut, collisionOccurred, holeHit, holeNum, resultValid
    );
endinterface

// File: rtl/multi_ball_hit_controller.sv
// Per-frame collision resolver: accumulates pixel-overlap events while the frame is drawn,
// then resolves one ball per clock into new velocities and pocket flags.
module multi_ball_hit_controller #(
    parameter int NUM_BALLS    = 2,
    parameter int NUM_HOLES    = 6,
    parameter int POS_W        = 11,
    parameter int VEL_W        = 11,
    parameter int BALL_SIZE    = 32,
    parameter int EDGE_MARGIN  = 2,
    parameter int TOP_OFFSET   = 0,
    parameter int DOWN_OFFSET  = 479,
    parameter int LEFT_OFFSET  = 0,
    parameter int RIGHT_OFFSET = 639
) (
    input  logic clk,
    input  logic resetN,
    multi_ball_hit_controller_if.slave bus
);
    localparam int CNT_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic signed [POS_W:0] LEFT_LIM  = (POS_W+1)'(LEFT_OFFSET + EDGE_MARGIN);
    localparam logic signed [POS_W:0] RIGHT_LIM = (POS_W+1)'(RIGHT_OFFSET - EDGE_MARGIN);
    localparam logic signed [POS_W:0] TOP_LIM   = (POS_W+1)'(TOP_OFFSET + EDGE_MARGIN);
    localparam logic signed [POS_W:0] DOWN_LIM  = (POS_W+1)'(DOWN_OFFSET - EDGE_MARGIN);
    localparam logic signed [POS_W:0] SIZE_M1   = (POS_W+1)'(BALL_SIZE - 1);
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};

    typedef enum logic [1:0] {COLLECT, RESOLVE, DONE} state_t;

    state_t                     state, nextState;
    logic [CNT_W-1:0]           counter;
    logic [NUM_BALLS-1:0]       borderLatch;
    logic [NUM_BALLS-1:0]       holeLatch;
    logic [NUM_BALLS-1:0]       pairLatch [NUM_BALLS];
    logic [2:0]                 holeIdx   [NUM_BALLS];
    logic [NUM_BALLS*VEL_W-1:0] velXOutReg, velYOutReg;
    logic [NUM_BALLS-1:0]       collReg, hitReg;
    logic [NUM_BALLS*3-1:0]     holeNumReg;

    logic                       anyHole;
    logic [2:0]                 firstHole;
    int                         kIdx, partner;
    logic                       partnerFound;
    logic signed [POS_W-1:0]    px, py;
    logic signed [POS_W:0]      pxe, pye;
    logic signed [VEL_W-1:0]    vx, vy;
    logic signed [VEL_W-1:0]    resVx, resVy;
    logic                       resColl, resHit;
    logic [2:0]                 resNum;

    // A component bounces only when the ball touches a side while still moving into it.
    function automatic logic signed [VEL_W-1:0] reflect(
        input logic signed [POS_W:0]   p,
        input logic signed [VEL_W-1:0] v,
        input logic signed [POS_W:0]   lo,
        input logic signed [POS_W:0]   hi
    );
        logic hitLow, hitHigh;
        hitLow  = (p <= lo) && v[VEL_W-1];
        hitHigh = ((p + SIZE_M1) >= hi) && !v[VEL_W-1] && (v != '0);
        if (hitLow || hitHigh)
            reflect = (v == VEL_MIN) ? VEL_MAX : -v;
        else
            reflect = v;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= COLLECT;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            COLLECT: if (bus.startOfFrame) nextState = RESOLVE;
            RESOLVE: if (counter == CNT_W'(NUM_BALLS - 1)) nextState = DONE;
            DONE:    nextState = COLLECT;
            default: nextState = COLLECT;
        endcase
    end

    always_comb begin
        anyHole   = |bus.holeDR;
        firstHole = '0;
        for (int h = NUM_HOLES - 1; h >= 0; h--)
            if (bus.holeDR[h]) firstHole = 3'(h);
    end

    // Priority: pocket, then ball-ball swap with lowest partner, then border bounce.
    always_comb begin
        kIdx         = int'(counter);
        px           = bus.ballPosX[kIdx*POS_W +: POS_W];
        py           = bus.ballPosY[kIdx*POS_W +: POS_W];
        pxe          = {px[POS_W-1], px};
        pye          = {py[POS_W-1], py};
        vx           = bus.ballVelX[kIdx*VEL_W +: VEL_W];
        vy           = bus.ballVelY[kIdx*VEL_W +: VEL_W];
        partner      = 0;
        partnerFound = 1'b0;
        for (int j = NUM_BALLS - 1; j >= 0; j--) begin
            if (j != kIdx && pairLatch[kIdx][j]) begin
                partner      = j;
                partnerFound = 1'b1;
            end
        end
        resVx   = vx;
        resVy   = vy;
        resColl = 1'b0;
        resHit  = 1'b0;
        resNum  = '0;
        if (holeLatch[kIdx]) begin
            resVx  = '0;
            resVy  = '0;
            resHit = 1'b1;
            resNum = holeIdx[kIdx];
        end else if (partnerFound) begin
            resVx   = bus.ballVelX[partner*VEL_W +: VEL_W];
            resVy   = bus.ballVelY[partner*VEL_W +: VEL_W];
            resColl = 1'b1;
        end else if (borderLatch[kIdx]) begin
            resVx   = reflect(pxe, vx, LEFT_LIM, RIGHT_LIM);
            resVy   = reflect(pye, vy, TOP_LIM, DOWN_LIM);
            resColl = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            counter     <= '0;
            borderLatch <= '0;
            holeLatch   <= '0;
            velXOutReg  <= '0;
            velYOutReg  <= '0;
            collReg     <= '0;
            hitReg      <= '0;
            holeNumReg  <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                pairLatch[i] <= '0;
                holeIdx[i]   <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    counter <= '0;
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        if (bus.ballDR[i] && bus.bordersDR)
                            borderLatch[i] <= 1'b1;
                        for (int j = 0; j < NUM_BALLS; j++)
                            if (j != i && bus.ballDR[i] && bus.ballDR[j])
                                pairLatch[i][j] <= 1'b1;
                        if (!holeLatch[i] && bus.ballDR[i] && anyHole) begin
                            holeLatch[i] <= 1'b1;
                            holeIdx[i]   <= firstHole;
                        end
                    end
                end
                RESOLVE: begin
                    counter                          <= counter + CNT_W'(1);
                    velXOutReg[kIdx*VEL_W +: VEL_W]  <= resVx;
                    velYOutReg[kIdx*VEL_W +: VEL_W]  <= resVy;
                    collReg[kIdx]                    <= resColl;
                    hitReg[kIdx]                     <= resHit;
                    holeNumReg[kIdx*3 +: 3]          <= resNum;
                end
                default: begin
                    counter     <= '0;
                    borderLatch <= '0;
                    holeLatch   <= '0;
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        pairLatch[i] <= '0;
                        holeIdx[i]   <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.ballVelXOut       = velXOutReg;
    assign bus.ballVelYOut       = velYOutReg;
    assign bus.collisionOccurred = collReg;
    assign bus.holeHit           = hitReg;
    assign bus.holeNum           = holeNumReg;
    assign bus.resultValid       = (state == DONE);
endmodule

// File: tb/tb_multi_ball_hit_controller.sv
// Bench for multi_ball_hit_controller: directed frames plus randomized frames checked
// against a frame-level reference model of the collision rules.
module tb_multi_ball_hit_controller;
    localparam int NB = 3;
    localparam int NH = 6;
    localparam int PW = 11;
    localparam int VW = 11;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    multi_ball_hit_controller_if #(.NUM_BALLS(NB), .NUM_HOLES(NH), .POS_W(PW), .VEL_W(VW)) bus();

    multi_ball_hit_controller #(.NUM_BALLS(NB), .NUM_HOLES(NH), .POS_W(PW), .VEL_W(VW)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int posX[NB], posY[NB], velX[NB], velY[NB];
    bit mBorder[NB], mHole[NB], mPair[NB][NB];
    int mHoleIdx[NB];

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic signed [31:0] outVx(input int i);
        logic signed [VW-1:0] v;
        v = bus.ballVelXOut[i*VW +: VW];
        return 32'(v);
    endfunction

    function automatic logic signed [31:0] outVy(input int i);
        logic signed [VW-1:0] v;
        v = bus.ballVelYOut[i*VW +: VW];
        return 32'(v);
    endfunction

    function automatic int reflectM(input int p, input int v, input int lo, input int hi);
        if ((p <= lo + 2 && v < 0) || (p + 31 >= hi - 2 && v > 0))
            return (v == -1024) ? 1023 : -v;
        return v;
    endfunction

    task automatic setBall(input int i, input int x, input int y, input int vx, input int vy);
        posX[i] = x; posY[i] = y; velX[i] = vx; velY[i] = vy;
        bus.ballPosX[i*PW +: PW] = PW'(x);
        bus.ballPosY[i*PW +: PW] = PW'(y);
        bus.ballVelX[i*VW +: VW] = VW'(vx);
        bus.ballVelY[i*VW +: VW] = VW'(vy);
    endtask

    task automatic clearModel();
        for (int i = 0; i < NB; i++) begin
            mBorder[i] = 0; mHole[i] = 0; mHoleIdx[i] = 0;
            for (int j = 0; j < NB; j++) mPair[i][j] = 0;
        end
    endtask

    task automatic zeroDR();
        bus.ballDR = '0; bus.bordersDR = 1'b0; bus.holeDR = '0; bus.startOfFrame = 1'b0;
    endtask

    // Drive one collect-phase cycle and fold it into the frame model.
    task automatic applyStimulus(input logic [NB-1:0] bdr, input logic brd,
                                 input logic [NH-1:0] hdr, input logic sof);
        @(negedge clk);
        bus.ballDR = bdr; bus.bordersDR = brd; bus.holeDR = hdr; bus.startOfFrame = sof;
        for (int i = 0; i < NB; i++) begin
            if (bdr[i] && brd) mBorder[i] = 1;
            for (int j = 0; j < NB; j++)
                if (j != i && bdr[i] && bdr[j]) mPair[i][j] = 1;
            if (!mHole[i] && bdr[i] && hdr != '0) begin
                mHole[i] = 1;
                for (int h = NH - 1; h >= 0; h--)
                    if (hdr[h]) mHoleIdx[i] = h;
            end
        end
    endtask

    task automatic modelBall(input int k, output int ex, output int ey, output int ecoll,
                             output int ehit, output int enum_);
        int partner;
        partner = -1;
        for (int j = NB - 1; j >= 0; j--)
            if (j != k && mPair[k][j]) partner = j;
        ex = velX[k]; ey = velY[k]; ecoll = 0; ehit = 0; enum_ = 0;
        if (mHole[k]) begin
            ex = 0; ey = 0; ehit = 1; enum_ = mHoleIdx[k];
        end else if (partner >= 0) begin
            ex = velX[partner]; ey = velY[partner]; ecoll = 1;
        end else if (mBorder[k]) begin
            ex = reflectM(posX[k], velX[k], 0, 639);
            ey = reflectM(posY[k], velY[k], 0, 479);
            ecoll = 1;
        end
    endtask

    // Pulse startOfFrame, wait for resultValid with a bound and compare all balls.
    task automatic resolveFrame(input logic [NB-1:0] bdr, input logic brd,
                                input logic [NH-1:0] hdr, input int extraSofAt);
        int lat, ex, ey, ec, eh, en;
        applyStimulus(bdr, brd, hdr, 1'b1);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.resultValid) begin
                lat = c;
                break;
            end
            bus.startOfFrame = (c == extraSofAt);
            bus.ballDR = NB'($urandom);
            bus.bordersDR = 1'($urandom);
            bus.holeDR = NH'($urandom);
        end
        zeroDR();
        checkOutput("latency", lat, NB + 1);
        for (int k = 0; k < NB; k++) begin
            modelBall(k, ex, ey, ec, eh, en);
            checkOutput($sformatf("velX[%0d]", k), outVx(k), ex);
            checkOutput($sformatf("velY[%0d]", k), outVy(k), ey);
            checkOutput($sformatf("coll[%0d]", k), {31'b0, bus.collisionOccurred[k]}, ec);
            checkOutput($sformatf("hit[%0d]", k), {31'b0, bus.holeHit[k]}, eh);
            if (eh != 0)
                checkOutput($sformatf("holeNum[%0d]", k), {29'b0, bus.holeNum[k*3 +: 3]}, en);
        end
        @(negedge clk);
        checkOutput("rvPulse", {31'b0, bus.resultValid}, 0);
        clearModel();
    endtask

    function automatic int randPos(input int hiEdge);
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 3));
            1: return hiEdge - 31 - 2 - 2 + int'($urandom_range(0, 5));
            default: return int'($urandom_range(3, hiEdge - 40));
        endcase
    endfunction

    function automatic int randVel();
        case ($urandom_range(0, 7))
            0: return -1024;
            1: return 0;
            default: return int'($urandom_range(0, 2047)) - 1024;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit sawValid;
        zeroDR();
        clearModel();
        for (int i = 0; i < NB; i++) setBall(i, 300, 200, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("rstVelX", 32'(bus.ballVelXOut), 0);
        checkOutput("rstColl", {29'b0, bus.collisionOccurred}, 0);
        checkOutput("rstHit", {29'b0, bus.holeHit}, 0);
        checkOutput("rstValid", {31'b0, bus.resultValid}, 0);
        resetN = 1'b1;

        $display("[TB] border bounce off left edge");
        setBall(0, 0, 100, -3, 2); setBall(1, 300, 200, 1, 1); setBall(2, 400, 300, 0, 0);
        applyStimulus(3'b001, 1'b1, '0, 1'b0);
        resolveFrame('0, 1'b0, '0, 0);
        checkOutput("t1vx0", outVx(0), 3);
        checkOutput("t1vy0", outVy(0), 2);
        checkOutput("t1coll", {29'b0, bus.collisionOccurred}, 1);

        $display("[TB] ball-ball swap");
        setBall(0, 200, 200, 4, 0); setBall(1, 220, 200, -1, 5);
        applyStimulus(3'b011, 1'b0, '0, 1'b0);
        resolveFrame('0, 1'b0, '0, 0);
        checkOutput("t2vx0", outVx(0), -1);
        checkOutput("t2vy0", outVy(0), 5);
        checkOutput("t2vx1", outVx(1), 4);
        checkOutput("t2coll", {29'b0, bus.collisionOccurred}, 3);

        $display("[TB] first hole wins");
        setBall(1, 630, 470, 2, 3);
        applyStimulus(3'b010, 1'b1, 6'b001000, 1'b0);
        applyStimulus(3'b010, 1'b0, 6'b000010, 1'b0);
        resolveFrame('0, 1'b0, '0, 0);
        checkOutput("t3hit", {29'b0, bus.holeHit}, 2);
        checkOutput("t3num1", {29'b0, bus.holeNum[3 +: 3]}, 3);
        checkOutput("t3vx1", outVx(1), 0);

        $display("[TB] saturation and moving-away cases");
        setBall(0, 620, 100, -1024, 0);
        applyStimulus(3'b001, 1'b1, '0, 1'b0);
        resolveFrame('0, 1'b0, '0, 0);
        checkOutput("t4right", outVx(0), -1024);
        setBall(0, 0, 100, -1024, 0);
        applyStimulus(3'b001, 1'b1, '0, 1'b0);
        resolveFrame('0, 1'b0, '0, 0);
        checkOutput("t4left", outVx(0), 1023);

        $display("[TB] idle frame with repeated startOfFrame");
        resolveFrame('0, 1'b0, '0, 2);
        checkOutput("t5coll", {29'b0, bus.collisionOccurred}, 0);

        $display("[TB] reset during resolve");
        applyStimulus(3'b110, 1'b1, '0, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b1);
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checkOutput("t6velX", 32'(bus.ballVelXOut), 0);
        checkOutput("t6coll", {29'b0, bus.collisionOccurred}, 0);
        sawValid = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resultValid) sawValid = 1;
        end
        resetN = 1'b1;
        repeat (NB + 2) begin
            @(negedge clk);
            if (bus.resultValid) sawValid = 1;
        end
        checkOutput("t6noValid", {31'b0, sawValid}, 0);
        clearModel();
        applyStimulus(3'b001, 1'b0, '0, 1'b0);
        resolveFrame('0, 1'b0, '0, 0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NB; i++)
                setBall(i, randPos(639), randPos(479), randVel(), randVel());
            for (int c = 0; c < int'($urandom_range(1, 5)); c++)
                applyStimulus(NB'($urandom & $urandom), 1'($urandom_range(0, 2) == 0),
                              ($urandom_range(0, 4) == 0) ? NH'($urandom) : '0, 1'b0);
            resolveFrame(NB'($urandom & $urandom), 1'($urandom), '0,
                         int'($urandom_range(0, NB)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_ball_hit_controller.md
Name: multi_ball_hit_controller

Overview:
Parametrised per-frame collision resolver for NUM_BALLS balls against the table borders, each other, and NUM_HOLES pockets. During the visible frame it accumulates pixel-overlap events from the drawing requests. On startOfFrame it resolves each ball serially, one per clock, into new velocities and hole-hit flags. Results sit between the object drawers and the ball physics blocks, and it drives ball-to-ball collisions as well as border collisions.

Parameters:
NUM_BALLS, 2, number of balls (2..16)
NUM_HOLES, 6, number of hole drawing requests (1..8)
POS_W, 11, signed position width
VEL_W, 11, signed velocity width
BALL_SIZE, 32, ball bitmap edge in pixels
EDGE_MARGIN, 2, pixel slack for border-side detection
TOP_OFFSET, 0; DOWN_OFFSET, 479; LEFT_OFFSET, 0; RIGHT_OFFSET, 639: playfield edges

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse at end of visible frame
ballDR  in  NUM_BALLS  per-ball drawing request
bordersDR  in  1  border drawing request
holeDR  in  NUM_HOLES  per-hole drawing request
ballPosX, ballPosY  in  NUM_BALLS*POS_W  packed signed top-left positions, ball i at [i*POS_W +: POS_W]
ballVelX, ballVelY  in  NUM_BALLS*VEL_W  packed signed velocities
ballVelXOut, ballVelYOut  out  NUM_BALLS*VEL_W  resolved velocities
collisionOccurred  out  NUM_BALLS  per-ball border or ball collision this frame
holeHit  out  NUM_BALLS  per-ball pocketed flag
holeNum  out  NUM_BALLS*3  packed hole index
resultValid  out  1  one-cycle pulse when all outputs are updated

Behaviour:
- States: COLLECT, RESOLVE, DONE. Reset state is COLLECT.
- On reset: all outputs 0, all latches cleared, ball counter 0.
- COLLECT, each clk, for ball i:
  - borderLatch[i] |= ballDR[i] & bordersDR.
  - pairLatch[i][j] (i<j) |= ballDR[i] & ballDR[j].
  - If holeLatch[i]=0 and ballDR[i] & any holeDR: set holeLatch[i] and store the lowest active hole index. Later hole hits in the same frame do not change the stored index.
- COLLECT with startOfFrame=1: go to RESOLVE, counter=0. DR inputs on that cycle are still accumulated.
- RESOLVE: DR inputs are ignored and startOfFrame is ignored. Each cycle, ball k=counter is resolved using the current pos/vel inputs, with this priority:
  1. holeLatch[k]: velOut=0, holeHit[k]=1, holeNum[k]=stored index, collisionOccurred[k]=0.
  2. Any pair latch involving k: j = lowest other index paired with k. velOut[k] = input vel of j (equal-mass swap). collisionOccurred[k]=1. holeHit[k]=0.
  3. borderLatch[k]: X component negated iff (posX <= LEFT_OFFSET+EDGE_MARGIN and velX<0) or (posX+BALL_SIZE-1 >= RIGHT_OFFSET-EDGE_MARGIN and velX>0). Y component uses the same rule with TOP/DOWN. Components that do not qualify pass through unchanged. collisionOccurred[k]=1.
  4. Otherwise: velOut = velIn, both flags 0.
- Counter increments each cycle. After k=NUM_BALLS-1 the next state is DONE.
- Negation saturates: -(-2^(VEL_W-1)) yields 2^(VEL_W-1)-1.
- Position arithmetic is done at POS_W+1 bits, so no wrap occurs.
- DONE (1 cycle): resultValid=1, all latches cleared, next state COLLECT.
- Latency: resultValid is high exactly NUM_BALLS+1 cycles after the startOfFrame cycle.
- Per-ball outputs update when that ball is resolved and are held until overwritten next frame. Consumers sample only on resultValid.
- Reset asserted mid-RESOLVE: immediate return to reset values. Partial results are discarded and no resultValid is issued.

Test Plan:
1. NUM_BALLS=2. Ball0 pos (0,100), vel (-3,2), ball0DR & bordersDR for 1 clk, then startOfFrame -> resultValid 3 cycles later, ball0 velOut (3,2), collisionOccurred=01.
2. Ball0 vel (4,0) and ball1 vel (-1,5) overlap DR -> velOut0=(-1,5), velOut1=(4,0), collisionOccurred=11.
3. Ball1DR & holeDR[3] then & holeDR[1] in the same frame, ball1 also border-latched -> holeHit=10, holeNum1=3, velOut1=(0,0), collisionOccurred[1]=0.
4. Ball at right edge with velX=-1024 and border latch, VEL_W=11 -> velX passes unchanged (moving away). Same ball at left edge with velX=-1024 -> 1023.
5. No overlaps, startOfFrame -> velOut equals velIn, all flags 0. A second startOfFrame during RESOLVE is ignored, with a single resultValid.
6. resetN low during RESOLVE of ball 1 -> outputs 0, no resultValid. The next frame resolves normally from cleared latches.
